// File: rtl/ln_pkg.sv
// Shared definitions for the ln range-reduction and polynomial stages.
package ln_pkg;
  localparam int FRAC_W = 16;
  localparam int X_W    = 18;

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
endpackage

// File: rtl/ln_norm_if.sv
// Request/response handshake bundle for ln_norm.
interface ln_norm_if #(
  parameter int WI = 32,
  parameter int EW = $clog2(WI+1)
);
  import ln_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [WI-1:0] d_in;
  logic          out_valid;
  logic          out_ready;
  logic [X_W-1:0] x_out;
  logic [EW-1:0] e_out;
  logic          zero_out;

  modport master (output in_valid, d_in, out_ready,
                  input  in_ready, out_valid, x_out, e_out, zero_out);
  modport slave  (input  in_valid, d_in, out_ready,
                  output in_ready, out_valid, x_out, e_out, zero_out);
endinterface

// File: rtl/ln_norm_frac_round.sv
// Fraction extraction from a normalized word; LN_NORM_ROUND_EN enables
// round-to-nearest with carry into the exponent.
module ln_frac_round
  import ln_pkg::*;
#(
  parameter int WI = 32,
  parameter int EW = $clog2(WI+1)
) (
  input  logic [WI-1:0]     sr,
  input  logic [EW-1:0]     ec,
  output logic [FRAC_W-1:0] frac,
  output logic [EW-1:0]     e_adj
);
  logic [FRAC_W-1:0] trunc;
  logic              unused_sr;

  // MSB is the implicit 1; narrow inputs are left-justified into the fraction
  generate
    if (WI-1 >= FRAC_W) begin : g_wide
      assign trunc = sr[WI-2 -: FRAC_W];
    end else begin : g_narrow
      assign trunc = {sr[WI-2:0], {(FRAC_W+1-WI){1'b0}}};
    end
  endgenerate

  assign unused_sr = ^sr;

`ifdef LN_NORM_ROUND_EN
  logic              rnd;
  logic [FRAC_W:0]   sum;

  generate
    if (WI >= 18) begin : g_rnd
      assign rnd = sr[WI-18];
    end else begin : g_nornd
      assign rnd = 1'b0;
    end
  endgenerate

  // a carry out means 1+x reached 2: fraction wraps to 0, exponent bumps
  assign sum   = {1'b0, trunc} + {{FRAC_W{1'b0}}, rnd};
  assign frac  = sum[FRAC_W-1:0];
  assign e_adj = ec + {{(EW-1){1'b0}}, sum[FRAC_W]};
`else
  assign frac  = trunc;
  assign e_adj = ec;
`endif
endmodule

// File: rtl/ln_norm.sv
// Serial normalizer: D = 2^e * (1+x), x emitted as Q16 for the ln polynomial.
// Optional rounding: define LN_NORM_ROUND_EN.
module ln_norm
  import ln_pkg::*;
#(
  parameter int WI = 32,
  parameter int EW = $clog2(WI+1)
) (
  input  logic       clk,
  input  logic       reset,
  ln_norm_if.slave   bus
);
  state_t            state;
  logic [WI-1:0]     sr;
  logic [EW-1:0]     ec;
  logic [FRAC_W-1:0] frac;
  logic [EW-1:0]     e_adj;

  ln_frac_round #(.WI(WI), .EW(EW)) u_frac (
    .sr    (sr),
    .ec    (ec),
    .frac  (frac),
    .e_adj (e_adj)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      sr            <= '0;
      ec            <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.x_out     <= '0;
      bus.e_out     <= '0;
      bus.zero_out  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sr           <= bus.d_in;
            ec           <= EW'(WI-1);
            bus.in_ready <= 1'b0;
            state        <= NORM;
          end
        end
        NORM: begin
          if (sr == '0) begin
            bus.zero_out  <= 1'b1;
            bus.x_out     <= '0;
            bus.e_out     <= '0;
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end else if (!sr[WI-1]) begin
            sr <= sr << 1;
            ec <= ec - EW'(1);
          end else begin
            bus.zero_out  <= 1'b0;
            bus.x_out     <= {{(X_W-FRAC_W){1'b0}}, frac};
            bus.e_out     <= e_adj;
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          // results stay put until the consumer takes them
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ln_norm.sv
// Self-checking bench for ln_norm (WI=32): directed table, random vs. model,
// backpressure and mid-operation reset sequences.
module tb_ln_norm;
  localparam int WI = 32;
  localparam int EW = $clog2(WI+1);

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  ln_norm_if #(.WI(WI), .EW(EW)) bus ();

  ln_norm #(.WI(WI), .EW(EW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    int          e;
    int          x;
    bit          z;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: highest set bit gives e; x = (D/2^e - 1) scaled by 2^16.
  task automatic model(input logic [31:0] d, output int e, output int x,
                       output bit z, output int lat);
    longint unsigned rem, xs;
    e = 0; x = 0; z = 0; lat = 1;
    if (d == 0) begin
      z = 1;
      return;
    end
    for (int i = 0; i < 32; i++) if (d[i]) e = i;
    rem = longint'(d) - (longint'(1) << e);
`ifdef LN_NORM_ROUND_EN
    xs = (((rem << 17) >> e) + 1) >> 1;
    if (xs == 65536) begin
      xs = 0;
      lat = 32 - e;
      e = e + 1;
    end else lat = 32 - e;
`else
    xs = (rem << 16) >> e;
    lat = 32 - e;
`endif
    x = int'(xs);
  endtask

  task automatic do_op(input logic [31:0] d, input int ee, input int ex,
                       input bit ez, input int elat, input string tag);
    int cnt;
    bit got;
    chk({tag, "_in_ready_pre"}, longint'(bus.in_ready), 1);
    bus.d_in     = d;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    cnt = 0;
    got = 0;
    while (cnt < 100 && !got) begin
      @(posedge clk);
      cnt++;
      #1;
      if (bus.out_valid) got = 1;
      else chk({tag, "_in_ready_busy"}, longint'(bus.in_ready), 0);
    end
    if (!got) begin
      chk({tag, "_timeout"}, 0, 1);
      return;
    end
    chk({tag, "_lat"}, cnt, elat);
    chk({tag, "_e"}, longint'(bus.e_out), ee);
    chk({tag, "_x"}, longint'(bus.x_out), ex);
    chk({tag, "_zero"}, longint'(bus.zero_out), ez);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    chk({tag, "_valid_drop"}, longint'(bus.out_valid), 0);
    chk({tag, "_in_ready_post"}, longint'(bus.in_ready), 1);
  endtask

  vec_t tbl[7];

  initial begin
    int e, x, lat;
    bit z, seen;
    logic [31:0] d;
    logic [17:0] hx;
    logic [EW-1:0] he;
    checks = 0;
    failures = 0;

    tbl[0] = '{32'h8000_0000, 31, 0,     0, 1};
    tbl[1] = '{32'h0000_0001, 0,  0,     0, 32};
    tbl[2] = '{32'h0000_0003, 1,  32768, 0, 31};
    tbl[3] = '{32'h0000_0005, 2,  16384, 0, 30};
    tbl[4] = '{32'h0001_2345, 16, 'h2345, 0, 16};
`ifdef LN_NORM_ROUND_EN
    tbl[5] = '{32'hFFFF_FFFF, 32, 0,     0, 1};
`else
    tbl[5] = '{32'hFFFF_FFFF, 31, 65535, 0, 1};
`endif
    tbl[6] = '{32'h0000_0000, 0,  0,     1, 1};

    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.d_in = '0;
    #12;
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_x", longint'(bus.x_out), 0);
    chk("rst_e", longint'(bus.e_out), 0);
    chk("rst_zero", longint'(bus.zero_out), 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1 chk("rst_in_ready", longint'(bus.in_ready), 1);

    foreach (tbl[i]) do_op(tbl[i].d, tbl[i].e, tbl[i].x, tbl[i].z, tbl[i].lat,
                           $sformatf("vec%0d", i));

    for (int n = 0; n < 40; n++) begin
      d = $urandom() >> $urandom_range(0, 31);
      if ($urandom_range(0, 9) == 0) d = 0;
      model(d, e, x, z, lat);
      do_op(d, e, x, z, lat, $sformatf("rnd%0d_%08h", n, d));
    end

    // backpressure: result held, extra in_valid pulses ignored
    bus.d_in = 32'd5;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (30) begin
      if (!bus.out_valid) begin
        @(posedge clk);
        #1;
      end
    end
    chk("bp_valid", longint'(bus.out_valid), 1);
    hx = bus.x_out;
    he = bus.e_out;
    chk("bp_x_first", longint'(hx), 16384);
    for (int c = 0; c < 5; c++) begin
      bus.d_in = $urandom();
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      chk($sformatf("bp_hold_valid%0d", c), longint'(bus.out_valid), 1);
      chk($sformatf("bp_hold_in_ready%0d", c), longint'(bus.in_ready), 0);
      chk($sformatf("bp_hold_x%0d", c), longint'(bus.x_out), 16384);
      chk($sformatf("bp_hold_e%0d", c), longint'(bus.e_out), 2);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    chk("bp_release_valid", longint'(bus.out_valid), 0);
    @(posedge clk);
    #1 chk("bp_no_extra_result", longint'(bus.out_valid), 0);
    chk("bp_idle_ready", longint'(bus.in_ready), 1);

    // reset in the middle of normalizing D=1
    bus.d_in = 32'd1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_valid", longint'(bus.out_valid), 0);
    chk("mid_rst_in_ready", longint'(bus.in_ready), 1);
    @(negedge clk) reset = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (bus.out_valid) seen = 1;
    end
    chk("mid_rst_no_result", longint'(seen), 0);
    do_op(32'd3, 1, 32768, 0, 31, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
